fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// - Instruction fetch stage. Generates the PC and issues in-order requests to instruction memory.
// - Buffers the returned words and presents {pc, inst, err} to the IF/ID pipeline register downstream.
// - That register latches on ok = inst_valid_o & inst_ready_i and inserts a bubble on flush.
// - Handles branch/exception redirects and downstream stalls without losing or duplicating instructions.
// PARAMETERS
// - XLEN      32            address/data width
// - RESET_PC  32'h0000_0000 first fetch address after reset
// - BUF_DEPTH 2             entries in the response buffer; also the max in-flight credit (power of 2, >=2)
// PORTS
// - clk            in  1     clock
// - rst_n          in  1     reset, asynchronous, active-low
// - redirect_i     in  1     redirect request from execute/commit; wins over everything
// - redirect_pc_i  in  XLEN  redirect target; bits [1:0] ignored (forced 0)
// - imem_req_o     out 1     memory request valid
// - imem_addr_o    out XLEN  word-aligned request address
// - imem_gnt_i     in  1     request accepted this cycle
// - imem_rvalid_i  in  1     response valid; in order, >=1 cycle after its gnt
// - imem_rdata_i   in  XLEN  response instruction word
// - imem_err_i     in  1     response bus error, qualified by rvalid
// - inst_valid_o   out 1     buffer head valid toward IF/ID
// - inst_ready_i   in  1     IF/ID can accept (its ok); low = stall
// - inst_o         out XLEN  instruction at buffer head
// - pc_o           out XLEN  PC of inst_o
// - inst_err_o     out 1     fetch fault flag of inst_o
// BEHAVIOUR
// - Reset values:
//   - imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, pc_o=0, inst_err_o=0.
//   - pc=RESET_PC, buffer empty, inflight=0, drop=0.
// - FSM:
//   - BOOT: the 1st cycle after reset release; no request. Goes to FETCH.
//   - FETCH: req=1 when inflight + occupancy < BUF_DEPTH. On req & !gnt, go to HOLD.
//   - HOLD: req=1 with addr stable until gnt. Return to FETCH on gnt.
// - A request is never withdrawn and its addr never changes while ungranted, even across a redirect.
// - On req & gnt:
//   - inflight++ and pc <= pc+4 (mod 2^XLEN, wraps silently).
//   - Next request may issue in the same-next cycle (1 req/cycle throughput).
// - On rvalid:
//   - inflight--.
//   - If drop>0: drop--, word discarded.
//   - Otherwise push {pc_tag, rdata, err} into the buffer; pc_tag comes from a parallel in-order PC queue.
// - Credit rule guarantees a push never finds the buffer full; assert on overflow.
// - Pop when inst_valid_o & inst_ready_i.
//   - Push and pop in the same cycle is legal at any occupancy, including empty bypass-free: data visible next cycle.
// - Latency: gnt at cycle t, rvalid at t+1 -> inst_valid_o at t+2.
// - Redirect (cycle t):
//   - Buffer cleared.
//   - drop <= inflight + (req&gnt at t) - (rvalid at t).
//   - pc <= redirect_pc_i & ~3.
//   - inst_valid_o forced 0 in cycle t.
//   - If in HOLD, the pending request completes with its old addr and is dropped; the new-PC request follows after its gnt.
//   - First new-PC request at t+1 (FETCH) or after the pending gnt (HOLD).
// - Redirect during drop>0 accumulates correctly; back-to-back redirects: the last one wins.
// - imem_err_i: entry carries err=1 and inst=32'h0000_0013 (NOP). Fetching continues; downstream raises the fault.
// - Reset mid-operation: all state returns to reset values immediately (async). Stale responses after release are unsupported.
// STRUCTURE
// - fetch_pkg: fetch_entry_t {pc, inst, err}; NOP_INST=32'h0000_0013; fetch_state_e {BOOT,FETCH,HOLD}.
// - Sub-module fetch_buffer: BUF_DEPTH circular FIFO of fetch_entry_t.
//   - Ports: push, pop, clear, full, empty, head.
//   - Pointers are log2(BUF_DEPTH)+1 bits with wrap bit.
// - Top keeps FSM, pc, inflight/drop counters, and PC tag queue (same depth).
// TESTING
// - Reset, always-gnt memory with 1-cycle rvalid, ready=1:
//   - req at cycle 1; pc_o sequence 0x0,0x4,0x8 on consecutive cycles from cycle 3.
// - ready=0 for 10 cycles:
//   - Req stops after BUF_DEPTH words in flight/buffered.
//   - Head stays pc 0x0.
//   - On release, no instruction lost or duplicated.
// - gnt low 3 cycles: req/addr held at 0x4, FSM in HOLD; stream resumes in order.
// - Redirect to 0x103 with 2 in flight:
//   - Both responses dropped.
//   - Next inst_valid_o shows pc_o=0x100.
//   - No stale pc 0x8/0xC emerges.
// - Redirect while in HOLD on 0x8: 0x8 still issued once then dropped; then req addr=0x200.
// - rvalid with err=1 at pc 0x4: inst_o=0x00000013, inst_err_o=1; the following pc 0x8 is normal.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
//   XLEN          : address/data width
//   NOP_INST      : word substituted for a faulting fetch
//   fetch_entry_t : {pc, inst, err} payload handed to IF/ID
//   fetch_state_e : request FSM states
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            err;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Circular FIFO of fetch entries between instruction memory and IF/ID.
//   clk, rst_n : clock, async active-low reset
//   push, data : write one entry
//   pop        : remove head entry
//   clear      : drop all entries (redirect), wins over push/pop
//   full/empty : occupancy flags; count = entries held
//   head       : entry at the read pointer (reset contents are zero)
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  data,
  input  logic          pop,
  input  logic          clear,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] count,
  output fetch_entry_t  head
);

  localparam int unsigned AW = PW - 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= data;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: generates the PC, issues in-order memory requests
// under a credit limit, buffers responses and presents {pc, inst, err} to IF/ID.
//   clk, rst_n                : clock, async active-low reset
//   redirect_i, redirect_pc_i : branch/exception redirect and target
//   imem_req_o, imem_addr_o   : request and word-aligned address
//   imem_gnt_i                : request accepted
//   imem_rvalid_i/rdata/err   : in-order response
//   inst_valid_o/ready_i      : handshake to IF/ID
//   inst_o, pc_o, inst_err_o  : buffer head payload
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            imem_err_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic            inst_err_o
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned AW = CW - 1;
  localparam int unsigned UW = CW + 1;

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] hold_addr;
  logic            hold_stale;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   buf_count;
  logic [XLEN-1:0] tag_mem [BUF_DEPTH];
  logic [AW-1:0]   tag_wr;
  logic [AW-1:0]   tag_rd;
  logic            buf_full;
  logic            buf_empty;
  logic            fire;
  logic            push;
  logic            pop;
  logic            credit;
  logic [UW-1:0]   used;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Head is hidden in the redirect cycle so nothing stale is consumed.
  assign inst_valid_o = ~buf_empty & ~redirect_i;
  assign pop          = inst_valid_o & inst_ready_i;

  // Credit counts the slot freed by a same-cycle pop to sustain 1 req/cycle.
  assign used   = UW'(inflight) + UW'(buf_count) - UW'(pop);
  assign credit = used < UW'(BUF_DEPTH);

  // Request generation; a HOLD request keeps its address until granted.
  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = pc;
    case (state)
      FETCH:   imem_req_o = credit & ~redirect_i;
      HOLD: begin
        imem_req_o  = 1'b1;
        imem_addr_o = hold_addr;
      end
      default: ;
    endcase
  end

  assign fire = imem_req_o & imem_gnt_i;
  assign push = imem_rvalid_i & (drop == '0) & ~redirect_i;

  always_comb begin
    push_entry.pc   = tag_mem[tag_rd];
    push_entry.inst = imem_err_i ? NOP_INST : imem_rdata_i;
    push_entry.err  = imem_err_i;
  end

  // PC tag queue: one entry per granted request, retired by its response.
  always_ff @(posedge clk) begin
    if (fire) tag_mem[tag_wr] <= imem_addr_o;
  end

  // FSM, PC, and in-flight/drop bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      hold_addr  <= RESET_PC;
      hold_stale <= 1'b0;
      inflight   <= '0;
      drop       <= '0;
      tag_wr     <= '0;
      tag_rd     <= '0;
    end else begin
      inflight <= inflight + CW'(fire) - CW'(imem_rvalid_i);
      if (fire)          tag_wr <= tag_wr + AW'(1);
      if (imem_rvalid_i) tag_rd <= tag_rd + AW'(1);

      // Everything outstanding after a redirect belongs to the old stream;
      // a stale HOLD request adds itself to drop when it is finally granted.
      if (redirect_i)
        drop <= inflight + CW'(fire) - CW'(imem_rvalid_i);
      else
        drop <= drop - CW'(imem_rvalid_i && (drop != '0))
                     + CW'(fire && (state == HOLD) && hold_stale);

      if (state == HOLD && redirect_i && !imem_gnt_i) hold_stale <= 1'b1;
      else if (fire)                                  hold_stale <= 1'b0;

      if (redirect_i)
        pc <= redirect_pc_i & ~XLEN'(3);
      else if (fire && !(state == HOLD && hold_stale))
        pc <= imem_addr_o + XLEN'(4);

      case (state)
        BOOT:  state <= FETCH;
        FETCH: begin
          if (imem_req_o && !imem_gnt_i) begin
            state     <= HOLD;
            hold_addr <= pc;
          end
        end
        HOLD:    if (imem_gnt_i) state <= FETCH;
        default: state <= BOOT;
      endcase
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .data  (push_entry),
    .pop   (pop),
    .clear (redirect_i),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count),
    .head  (head)
  );

  assign inst_o     = head.inst;
  assign pc_o       = head.pc;
  assign inst_err_o = head.err;

  // The credit limit guarantees a response always finds a free slot.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && buf_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed timing scenarios plus randomized
// memory/stall/redirect traffic checked against a program-order model.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_err;

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .imem_err_i    (imem_err),
    .inst_valid_o  (inst_valid),
    .inst_ready_i  (inst_ready),
    .inst_o        (inst),
    .pc_o          (pc),
    .inst_err_o    (inst_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          accepted = 0;
  logic [31:0] exp_pc = 32'h0;

  int unsigned gnt_pct = 100, ready_pct = 100, lat_min = 1, lat_max = 1, redir_pm = 0;
  logic        redir_pending = 1'b0;
  logic [31:0] redir_tgt = '0;

  logic        s_req, s_fire, s_valid, s_pop, s_err, prev_hold = 1'b0;
  logic [31:0] s_addr, s_pc, s_inst, prev_addr = '0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return a[5:2] == 4'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive memory/IF-ID/redirect, sample, check against the model.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = data_of(mq[0].addr);
      imem_err    = err_of(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      imem_err    = 1'($urandom);
    end
    imem_gnt   = ($urandom_range(99) < gnt_pct);
    inst_ready = ($urandom_range(99) < ready_pct);
    if (!redir_pending && $urandom_range(999) < redir_pm) begin
      redir_pending = 1'b1;
      redir_tgt = ($urandom_range(9) == 0) ? 32'hFFFF_FFF9 : $urandom;
    end
    redirect      = redir_pending;
    redirect_pc   = redir_tgt;
    redir_pending = 1'b0;
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_fire  = imem_req & imem_gnt;
    s_valid = inst_valid;
    s_pop   = inst_valid & inst_ready;
    s_pc    = pc;
    s_inst  = inst;
    s_err   = inst_err;

    if (prev_hold) begin
      chk("hold_req", 32'(s_req), 32'd1);
      chk("hold_addr", s_addr, prev_addr);
    end
    if (redirect) chk("redir_valid", 32'(s_valid), 32'd0);
    if (s_pop) begin
      chk("stream_pc", s_pc, exp_pc);
      chk("stream_inst", s_inst, err_of(exp_pc) ? NOP : data_of(exp_pc));
      chk("stream_err", 32'(s_err), 32'(err_of(exp_pc)));
      exp_pc = exp_pc + 32'd4;
      accepted++;
    end
    if (redirect) exp_pc = redirect_pc & ~32'h3;

    if (imem_rvalid) mq.delete(0);
    if (s_fire) mq.push_back('{addr: s_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
    chk("credit", 32'(mq.size() <= DEPTH), 32'd1);
    prev_hold = s_req & ~imem_gnt;
    prev_addr = s_addr;
  endtask

  initial begin
    logic [31:0] old;
    logic        found;
    int          acc0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_err", 32'(inst_err), 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    imem_gnt   = 1'b1;
    inst_ready = 1'b1;
    #1;
    chk("boot_req", 32'(imem_req), 32'd0);

    // Ideal memory: first request at cycle 1, pc 0,4,8 from cycle 3
    step(); chk("c1_req", 32'(s_req), 32'd1); chk("c1_addr", s_addr, 32'h0);
    step(); chk("c2_valid", 32'(s_valid), 32'd0);
    step(); chk("c3_valid", 32'(s_valid), 32'd1); chk("c3_pc", s_pc, 32'h0);
    step(); chk("c4_pc", s_pc, 32'h4); chk("c4_inst_nop", s_inst, NOP); chk("c4_err", 32'(s_err), 32'd1);
    step(); chk("c5_pc", s_pc, 32'h8); chk("c5_err", 32'(s_err), 32'd0);

    // Downstream stall for 10 cycles
    ready_pct = 0;
    step();
    chk("stall_valid0", 32'(s_valid), 32'd1);
    old = s_pc;
    repeat (9) step();
    chk("stall_req", 32'(s_req), 32'd0);
    chk("stall_valid", 32'(s_valid), 32'd1);
    chk("stall_head", s_pc, old);
    ready_pct = 100;
    repeat (3) step();

    // Grant withheld for 3 cycles
    gnt_pct = 0;
    step();
    old = s_addr;
    chk("gntlow_req0", 32'(s_req), 32'd1);
    repeat (2) begin
      step();
      chk("gntlow_req", 32'(s_req), 32'd1);
      chk("gntlow_addr", s_addr, old);
    end
    gnt_pct = 100;
    repeat (4) step();

    // Redirect to 0x103 with two requests in flight
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (mq.size() == 2) found = 1'b1;
    end
    chk("inflight2_reached", 32'(found), 32'd1);
    redir_pending = 1'b1; redir_tgt = 32'h0000_0103;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (s_pop) begin
        found = 1'b1;
        chk("redir_first_pc", s_pc, 32'h0000_0100);
      end
    end
    chk("redir_timeout", 32'(found), 32'd1);

    // Redirect while a request is held
    lat_min = 1; lat_max = 1; gnt_pct = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (s_req) found = 1'b1;
    end
    chk("hold_entry", 32'(found), 32'd1);
    old = s_addr;
    redir_pending = 1'b1; redir_tgt = 32'h0000_0200;
    step();
    chk("hold_redir_addr", s_addr, old);
    gnt_pct = 100;
    step();
    chk("hold_old_fire", 32'(s_fire), 32'd1);
    chk("hold_old_addr", s_addr, old);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (s_fire) begin
        found = 1'b1;
        chk("hold_new_addr", s_addr, 32'h0000_0200);
      end
    end
    chk("hold_new_timeout", 32'(found), 32'd1);

    // Randomized traffic
    gnt_pct = 70; ready_pct = 70; lat_min = 1; lat_max = 3; redir_pm = 20;
    repeat (3000) step();

    // Drain at full rate and confirm forward progress
    redir_pm = 0; gnt_pct = 100; ready_pct = 100; lat_max = 1;
    acc0 = accepted;
    repeat (30) step();
    chk("progress", 32'(accepted - acc0 >= 20), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
